// File: rtl/piso_burst_scheduler_if.sv
// Bus bundle for piso_burst_scheduler.
//   i_req    : per-requester request, held with a stable bundle until granted
//   i_bundle : requester r word b at [(r*BEATS+b)*DATA_W +: DATA_W]
//   o_gnt    : one-hot grant pulse in the capture cycle
//   o_data/o_valid/i_ready : serialized beat stream
//   o_first/o_last : beat 0 / beat BEATS-1 markers (qualified by o_valid)
//   o_src    : requester owning the bundle being streamed
//   o_busy   : scheduler is streaming a bundle
// master = scheduler side, slave = producer/consumer side.
interface piso_burst_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 4,
    parameter int BEATS  = 3
) ();
    logic [NREQ-1:0]              i_req;
    logic [NREQ*BEATS*DATA_W-1:0] i_bundle;
    logic [NREQ-1:0]              o_gnt;
    logic [DATA_W-1:0]            o_data;
    logic                         o_valid;
    logic                         i_ready;
    logic                         o_first;
    logic                         o_last;
    logic [$clog2(NREQ)-1:0]      o_src;
    logic                         o_busy;

    modport master (
        input  i_req, i_bundle, i_ready,
        output o_gnt, o_data, o_valid, o_first, o_last, o_src, o_busy
    );

    modport slave (
        output i_req, i_bundle, i_ready,
        input  o_gnt, o_data, o_valid, o_first, o_last, o_src, o_busy
    );
endinterface

// File: rtl/piso_burst_scheduler.sv
// piso_burst_scheduler: round-robin arbiter in front of one BEATS-word
// parallel-in/serial-out serializer.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : piso_burst_scheduler_if.master (request/bundle in, grant out,
//             valid/ready beat stream out with first/last/src/busy tags)
// A granted bundle is captured into holding registers; beats are muxed out of
// those registers only, so producers may change i_bundle right after grant.
module piso_burst_scheduler #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 4,
    parameter int BEATS  = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    piso_burst_scheduler_if.master bus
);
    localparam int SW = $clog2(NREQ);
    localparam int BW = $clog2(BEATS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [BW-1:0]                 beat_q;
    logic [SW-1:0]                 rr_q;
    logic [SW-1:0]                 src_q;
    logic [BEATS-1:0][DATA_W-1:0]  hold_q;

    logic [SW-1:0]                 winner;
    logic                          last_beat;
    logic                          accept;
    logic                          can_capture;
    logic                          grant_en;

    // Round-robin scan starting just above the last winner. The wrap is an
    // explicit compare so non-power-of-two NREQ behaves.
    always_comb begin
        logic [SW-1:0] idx;
        logic          found;
        winner = '0;
        found  = 1'b0;
        idx    = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == SW'(NREQ-1)) ? '0 : idx + 1'b1;
            if (bus.i_req[idx] && !found) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign last_beat   = (beat_q == BW'(BEATS-1));
    assign accept      = (state_q == SEND) && bus.i_ready;
    // Capture in IDLE, or on the accepted last beat for back-to-back bundles.
    assign can_capture = (state_q == IDLE) || (accept && last_beat);
    assign grant_en    = can_capture && (|bus.i_req) && i_rst_n;

    assign bus.o_gnt   = grant_en ? (NREQ'(1) << winner) : '0;
    assign bus.o_valid = (state_q == SEND);
    assign bus.o_busy  = (state_q == SEND);
    assign bus.o_data  = hold_q[beat_q];
    assign bus.o_first = (state_q == SEND) && (beat_q == '0);
    assign bus.o_last  = (state_q == SEND) && last_beat;
    assign bus.o_src   = src_q;

    always_comb begin
        state_d = state_q;
        if (grant_en)
            state_d = SEND;
        else if (accept && last_beat)
            state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            beat_q <= '0;
            rr_q   <= SW'(NREQ-1);
            src_q  <= '0;
            hold_q <= '0;
        end else if (grant_en) begin
            for (int b = 0; b < BEATS; b++)
                hold_q[b] <= bus.i_bundle[(int'(winner)*BEATS + b)*DATA_W +: DATA_W];
            src_q  <= winner;
            rr_q   <= winner;
            beat_q <= '0;
        end else if (accept && !last_beat) begin
            beat_q <= beat_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_burst_scheduler.sv
module tb_piso_burst_scheduler;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int BT = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
        logic [1:0]    src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_burst_scheduler_if #(.DATA_W(DW), .NREQ(NR), .BEATS(BT)) bus ();

    piso_burst_scheduler #(.DATA_W(DW), .NREQ(NR), .BEATS(BT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    logic [DW-1:0] wd [NR][BT];
    exp_t          sb [$];
    int            vectors = 0;
    int            miscompares = 0;

    always_comb begin
        bus.i_bundle = '0;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < BT; b++)
                bus.i_bundle[(r*BT+b)*DW +: DW] = wd[r][b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of requester r, taken from the words it presents now.
    task automatic push(input int r);
        for (int b = 0; b < BT; b++)
            sb.push_back('{wd[r][b], (b == 0), (b == BT-1), 2'(r)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat is popped and compared.
    always @(negedge clk) begin
        if (bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus.o_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_data",  bus.o_data,         e.data);
                chk("beat_first", 32'(bus.o_first),   32'(e.first));
                chk("beat_last",  32'(bus.o_last),    32'(e.last));
                chk("beat_src",   32'(bus.o_src),     32'(e.src));
            end
        end
    end

    initial begin
        logic [3:0] oh;
        rst_n       = 1'b0;
        bus.i_req   = 4'b0001;
        bus.i_ready = 1'b1;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < BT; b++)
                wd[r][b] = '0;
        step();
        step();
        // Reset state; a request during reset must not be granted.
        @(negedge clk);
        chk("rst_valid", 32'(bus.o_valid), 32'(0));
        chk("rst_busy",  32'(bus.o_busy),  32'(0));
        chk("rst_first", 32'(bus.o_first), 32'(0));
        chk("rst_last",  32'(bus.o_last),  32'(0));
        chk("rst_src",   32'(bus.o_src),   32'(0));
        chk("rst_gnt",   32'(bus.o_gnt),   32'(0));
        step();
        bus.i_req = 4'b0000;
        rst_n     = 1'b1;
        step();

        // Single bundle from requester 0.
        wd[0][0] = 32'h11; wd[0][1] = 32'h22; wd[0][2] = 32'h33;
        bus.i_req = 4'b0001;
        @(negedge clk);
        chk("single_gnt", 32'(bus.o_gnt), 32'(4'b0001));
        push(0);
        step();
        bus.i_req = 4'b0000;
        for (int i = 0; i < BT; i++) begin
            @(negedge clk);
            chk("single_valid", 32'(bus.o_valid), 32'(1));
            step();
        end
        @(negedge clk);
        chk("single_after_valid", 32'(bus.o_valid), 32'(0));
        chk("single_after_busy",  32'(bus.o_busy),  32'(0));

        // Fresh reset so requester 0 leads, then all four request constantly.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < BT; b++)
                wd[r][b] = 32'h100 * (r + 1) + 32'(b);
        bus.i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            oh = 4'b0001 << (k % 4);
            chk("rr_gnt", 32'(bus.o_gnt), 32'(oh));
            if (k > 0) chk("rr_valid_at_gnt", 32'(bus.o_valid), 32'(1));
            push(k % 4);
            step();
            if (k == 4) bus.i_req = 4'b0000;
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                chk("rr_gnt_idle", 32'(bus.o_gnt), 32'(0));
                chk("rr_valid_gap", 32'(bus.o_valid), 32'(1));
                step();
            end
        end
        @(negedge clk);
        chk("rr_end_last", 32'(bus.o_last), 32'(1));
        chk("rr_end_gnt",  32'(bus.o_gnt),  32'(0));
        step();
        @(negedge clk);
        chk("rr_end_valid", 32'(bus.o_valid), 32'(0));
        step();

        // Requester 2 with a stall on beat 1 while requester 0 also asks.
        // rr is now 0, so requester 2 wins; then rr=2 wraps past 3 to 0.
        wd[2][0] = 32'hA; wd[2][1] = 32'hB; wd[2][2] = 32'hC;
        bus.i_req = 4'b0100;
        @(negedge clk);
        chk("stall_gnt2", 32'(bus.o_gnt), 32'(4'b0100));
        push(2);
        step();
        bus.i_req = 4'b0101;
        @(negedge clk);
        chk("stall_beat0_gnt", 32'(bus.o_gnt), 32'(0));
        step();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_data", bus.o_data,         32'hB);
            chk("stall_last", 32'(bus.o_last),    32'(0));
            chk("stall_gnt",  32'(bus.o_gnt),     32'(0));
            step();
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_gnt", 32'(bus.o_gnt), 32'(0));
        step();
        @(negedge clk);
        chk("wrap_gnt0", 32'(bus.o_gnt), 32'(4'b0001));
        push(0);
        step();
        // Captured words must stream even though the bundle changes now.
        bus.i_req = 4'b0000;
        wd[0][0] = 32'hDEAD0; wd[0][1] = 32'hDEAD1; wd[0][2] = 32'hDEAD2;
        @(negedge clk);
        chk("wrap_first", 32'(bus.o_first), 32'(1));
        step();
        step();
        step();
        @(negedge clk);
        chk("wrap_end_valid", 32'(bus.o_valid), 32'(0));

        // Reset in the middle of a bundle.
        step();
        bus.i_req = 4'b0100;
        @(negedge clk);
        chk("abort_gnt2", 32'(bus.o_gnt), 32'(4'b0100));
        push(2);
        step();
        bus.i_req = 4'b0000;
        step();
        rst_n     = 1'b0;
        bus.i_req = 4'b0010;
        @(negedge clk);
        chk("abort_rst_gnt", 32'(bus.o_gnt), 32'(0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_valid",  32'(bus.o_valid), 32'(0));
        chk("abort_busy",   32'(bus.o_busy),  32'(0));
        chk("abort_gnt1",   32'(bus.o_gnt),   32'(4'b0010));
        chk("abort_left",   32'(sb.size()),   32'(1));
        void'(sb.pop_back());
        push(1);
        step();
        bus.i_req = 4'b0000;
        for (int i = 0; i < BT + 2; i++) step();
        @(negedge clk);
        chk("final_valid", 32'(bus.o_valid), 32'(0));
        chk("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
